// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the parametrised RAM controller.
// Holds the FSM state encoding and the byte-strobe to bit-mask expansion.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  localparam int MAX_DATA_W = 128;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  // Each strobe bit selects one whole byte lane of the data word.
  function automatic logic [MAX_DATA_W-1:0] strb_to_mask(input logic [MAX_STRB_W-1:0] strb);
    logic [MAX_DATA_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ram_ctrl_mem.sv
// Single-port synchronous RAM with bit-masked writes and a registered read port.
// Storage has no reset; the controller zero-fills it after every reset.
module ram_ctrl_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data is held between reads so the response stays stable while stalled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_ctrl_param.sv
// RAM controller: zero-fill after reset, then serialised read/write requests
// with valid/ready handshakes, byte strobes and out-of-range error responses.
module ram_ctrl_param
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_write,
  output logic                init_done
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t state, next_state;

  logic [ADDR_W-1:0] init_cnt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              rsp_err_q;
  logic              rsp_write_q;
  logic              init_done_q;
  logic              in_range;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_rdata;
  logic [MAX_DATA_W-1:0] full_mask;

  // Compare one bit wider so DEPTH = 2^ADDR_W never flags an error.
  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_done_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rsp_err_q   <= 1'b0;
      rsp_write_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
        if (init_cnt == LAST_ADDR) begin
          init_done_q <= 1'b1;
        end
      end
      if (state == IDLE && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        strb_q  <= req_strb;
      end
      if (state == WRITE || state == READ) begin
        rsp_err_q   <= !in_range;
        rsp_write_q <= write_q;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (init_cnt == LAST_ADDR) next_state = IDLE;
      IDLE:    if (req_valid) next_state = req_write ? WRITE : READ;
      WRITE:   next_state = RESP;
      READ:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // RAM port is shared between the zero-fill sweep and request accesses.
  always_comb begin
    full_mask = strb_to_mask(MAX_STRB_W'(strb_q));
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = full_mask[DATA_W-1:0];
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = init_cnt;
        mem_wdata = '0;
        mem_wmask = '1;
      end
      WRITE:   mem_we = in_range;
      READ:    mem_re = in_range;
      default: ;
    endcase
  end

  ram_ctrl_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .wmask(mem_wmask),
    .rdata(mem_rdata)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_write = rsp_write_q;
  assign init_done = init_done_q;
  assign rsp_rdata = (state == RESP && !rsp_write_q && !rsp_err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_ctrl_param.sv
// Directed bench for ram_ctrl_param (DATA_W=32, ADDR_W=5, DEPTH=20): vector table
// plus hand-written sequences for init timing, response stall and mid-write reset.
module tb_ram_ctrl_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 20;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_write;
  logic              init_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        strb;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[15];

  ram_ctrl_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_strb (req_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .rsp_write(rsp_write),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Offer a request and return at the negedge after the accepting posedge.
  task automatic acceptReq(input logic write, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [3:0] strb);
    int waited;
    waited = 0;
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 64'(req_ready), 64'd1);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~write;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_strb  = ~strb;
  endtask

  task automatic applyStimulus(input vec_t v);
    acceptReq(v.write, v.addr, v.wdata, v.strb);
    checkOutput("rsp_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    checkOutput("rsp_err", 64'(rsp_err), 64'(v.exp_err));
    checkOutput("rsp_write", 64'(rsp_write), 64'(v.write));
    @(negedge clk);
    checkOutput("rsp_done", 64'(rsp_valid), 64'd0);
  endtask

  task automatic checkInitTiming();
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      if (req_ready || init_done) begin
        checkOutput("init_early", 64'(i), 64'(DEPTH));
      end
    end
    @(negedge clk);
    checkOutput("init_done", 64'(init_done), 64'd1);
    checkOutput("init_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_rsp_write", 64'(rsp_write), 64'd0);
    checkOutput("rst_init_done", 64'(init_done), 64'd0);
  endtask

  initial begin
    vec_t rv;

    vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 5'd3,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 5'd7,  32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 5'd7,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 5'd7,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 5'd25, 32'h99999999, 4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 5'd25, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 5'd9,  32'h0,        4'hF, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 5'd12, 32'hCAFEF00D, 4'h0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 5'd12, 32'h0,        4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 5'd31, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 5'd19, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 5'd19, 32'h0,        4'hF, 32'h12345678, 1'b0};
    vecs[13] = '{1'b0, 5'd20, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        4'hF, 32'h0,        1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
    checkInitTiming();

    $display("[TB] zero-fill readback");
    for (int a = 0; a < DEPTH; a++) begin
      rv = '{1'b0, ADDR_W'(a), 32'h0, 4'hF, 32'h0, 1'b0};
      applyStimulus(rv);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] response stall");
    rsp_ready = 1'b0;
    acceptReq(1'b0, 5'd3, 32'h0, 4'hF);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'd3;
    req_wdata = 32'h0BADF00D;
    req_strb  = 4'hF;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      checkOutput("stall_err", 64'(rsp_err), 64'd0);
      checkOutput("stall_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release", 64'(rsp_valid), 64'd0);
    applyStimulus(vecs[1]);

    $display("[TB] reset during write");
    rv = '{1'b1, 5'd2, 32'h00000055, 4'hF, 32'h0, 1'b0};
    applyStimulus(rv);
    acceptReq(1'b1, 5'd2, 32'h00000066, 4'hF);
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    repeat (2) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
    checkInitTiming();
    rv = '{1'b0, 5'd2, 32'h0, 4'hF, 32'h0, 1'b0};
    applyStimulus(rv);
    rv = '{1'b0, 5'd3, 32'h0, 4'hF, 32'h0, 1'b0};
    applyStimulus(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
